// File: rtl/memu_pkg.sv
// memu_pkg: shared definitions for the memory-access stage.
//   - mem_op encodings (loads and stores share the 3-bit field)
//   - FSM state encoding (2 bits)
//   - ex_to_mem_bus field offsets, packed MSB..LSB as
//     {mem_op[2:0], mem_re, mem_we, st_data, alu_res, regAddr, regW}
package memu_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Bus field offsets; regW is bit 0, regAddr starts at bit 1.
  localparam int unsigned BUS_REGW_BIT = 0;
  localparam int unsigned BUS_RA_LSB   = 1;

  function automatic int unsigned bus_alu_lsb(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic int unsigned bus_st_lsb(input int unsigned aw, input int unsigned dw);
    return aw + 1 + dw;
  endfunction

  function automatic int unsigned bus_we_bit(input int unsigned aw, input int unsigned dw);
    return aw + 1 + 2 * dw;
  endfunction

  function automatic int unsigned bus_re_bit(input int unsigned aw, input int unsigned dw);
    return aw + 2 + 2 * dw;
  endfunction

  function automatic int unsigned bus_op_lsb(input int unsigned aw, input int unsigned dw);
    return aw + 3 + 2 * dw;
  endfunction

endpackage

// File: rtl/memu_align.sv
// memu_align: combinational byte-lane logic for memu (4 lanes, 32-bit word).
//   op_i/off_i  : mem_op and byte offset of the registered instruction
//   store_i     : registered instruction is a store (wstrb forced 0 otherwise)
//   st_data_i   : store data, replicated across lanes -> wdata_o / wstrb_o
//   rdata_i     : read word, shifted/extended -> ld_data_o
//   chk_*       : incoming instruction fields for misalign detect (only built
//                 with MEMU_MISALIGN_CHECK_EN) -> misalign_o
module memu_align
  import memu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
`ifdef MEMU_MISALIGN_CHECK_EN
  input  logic                  chk_mem_i,
  input  logic [2:0]            chk_op_i,
  input  logic [1:0]            chk_off_i,
  output logic                  misalign_o,
`endif
  input  logic [2:0]            op_i,
  input  logic [1:0]            off_i,
  input  logic                  store_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o
);

  logic [DATA_WIDTH-1:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (op_i)
      OP_LB:   ld_data_o = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      OP_LH:   ld_data_o = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      OP_LW:   ld_data_o = rdata_i;
      OP_LBU:  ld_data_o = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      OP_LHU:  ld_data_o = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

  // Upper lanes shifted past bit 3 fall off the 4-bit strobe: a misaligned
  // access simply loses the bytes that would land in the next word.
  always_comb begin
    case (op_i)
      OP_SB: begin
        wdata_o = {4{st_data_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      OP_SH: begin
        wdata_o = {2{st_data_i[15:0]}};
        wstrb_o = 4'b0011 << off_i;
      end
      default: begin
        wdata_o = st_data_i;
        wstrb_o = 4'b1111;
      end
    endcase
    if (!store_i) wstrb_o = 4'b0000;
  end

`ifdef MEMU_MISALIGN_CHECK_EN
  // Halfword codes double as LH/SH, word code as LW/SW.
  assign misalign_o = chk_mem_i &
                      ((((chk_op_i == OP_LH) | (chk_op_i == OP_LHU)) & chk_off_i[0]) |
                       ((chk_op_i == OP_LW) & (chk_off_i != 2'b00)));
`endif

endmodule

// File: rtl/memu.sv
// memu: memory-access stage between execute and write-back.
//   clk, rst (async, active low)
//   ex_to_mem_bus/valid, mem_to_ex_ready : instruction in (valid/ready)
//   mem_to_wb_bus/valid, wb_to_mem_ready : {regData, regAddr, regW} out
//   dmem_req_* / dmem_addr/wen/wdata/wstrb : memory request
//   dmem_resp_valid/ready, dmem_rdata     : memory response
//   mem_misalign_err : 1-cycle pulse on the first HOLD cycle of a rejected
//                      misaligned access (MEMU_MISALIGN_CHECK_EN), else 0.
// Single entry, FSM IDLE -> REQ -> RESP -> HOLD; non-memory ops go
// IDLE -> HOLD. HOLD accepts the next instruction in the same cycle the
// current one leaves, so back-to-back ops see no bubble.
module memu
  import memu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2*DATA_WIDTH+ADDR_WIDTH+5:0] ex_to_mem_bus,
  input  logic                             ex_to_mem_valid,
  output logic                             mem_to_ex_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]   mem_to_wb_bus,
  output logic                             mem_to_wb_valid,
  input  logic                             wb_to_mem_ready,
  output logic                             dmem_req_valid,
  input  logic                             dmem_req_ready,
  output logic [DATA_WIDTH-1:0]            dmem_addr,
  output logic                             dmem_wen,
  output logic [DATA_WIDTH-1:0]            dmem_wdata,
  output logic [3:0]                       dmem_wstrb,
  input  logic                             dmem_resp_valid,
  output logic                             dmem_resp_ready,
  input  logic [DATA_WIDTH-1:0]            dmem_rdata,
  output logic                             mem_misalign_err
);

  localparam int unsigned ALU_LSB = bus_alu_lsb(ADDR_WIDTH);
  localparam int unsigned ST_LSB  = bus_st_lsb(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned WE_BIT  = bus_we_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned RE_BIT  = bus_re_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned OP_LSB  = bus_op_lsb(ADDR_WIDTH, DATA_WIDTH);

  logic [2:0]            in_op;
  logic                  in_re, in_we, in_regw;
  logic [DATA_WIDTH-1:0] in_st, in_alu;
  logic [ADDR_WIDTH-1:0] in_ra;

  assign in_op   = ex_to_mem_bus[OP_LSB +: 3];
  assign in_re   = ex_to_mem_bus[RE_BIT];
  assign in_we   = ex_to_mem_bus[WE_BIT];
  assign in_st   = ex_to_mem_bus[ST_LSB +: DATA_WIDTH];
  assign in_alu  = ex_to_mem_bus[ALU_LSB +: DATA_WIDTH];
  assign in_ra   = ex_to_mem_bus[BUS_RA_LSB +: ADDR_WIDTH];
  assign in_regw = ex_to_mem_bus[BUS_REGW_BIT];

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  re_q, re_d, we_q, we_d;
  logic [DATA_WIDTH-1:0] st_q, st_d, alu_q, alu_d, data_q, data_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic                  regw_q, regw_d;

  logic                  accept, mis_in;
  logic [DATA_WIDTH-1:0] ld_data;

  memu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
`ifdef MEMU_MISALIGN_CHECK_EN
    .chk_mem_i (in_re | in_we),
    .chk_op_i  (in_op),
    .chk_off_i (in_alu[1:0]),
    .misalign_o(mis_in),
`endif
    .op_i      (op_q),
    .off_i     (alu_q[1:0]),
    .store_i   (we_q & ~re_q),
    .st_data_i (st_q),
    .rdata_i   (dmem_rdata),
    .ld_data_o (ld_data),
    .wdata_o   (dmem_wdata),
    .wstrb_o   (dmem_wstrb)
  );

`ifndef MEMU_MISALIGN_CHECK_EN
  assign mis_in = 1'b0;
`endif

  // Gated by rst so the stage advertises nothing while held in reset.
  assign mem_to_ex_ready = rst & ((state_q == ST_IDLE) |
                                  ((state_q == ST_HOLD) & wb_to_mem_ready));
  assign accept          = ex_to_mem_valid & mem_to_ex_ready;

  assign dmem_req_valid  = (state_q == ST_REQ);
  assign dmem_resp_ready = (state_q == ST_RESP);
  assign dmem_addr       = {alu_q[DATA_WIDTH-1:2], 2'b00};
  assign dmem_wen        = we_q & ~re_q;   // re+we together behaves as a load
  assign mem_to_wb_valid = (state_q == ST_HOLD);
  assign mem_to_wb_bus   = {data_q, ra_q, regw_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    re_d    = re_q;
    we_d    = we_q;
    st_d    = st_q;
    alu_d   = alu_q;
    ra_d    = ra_q;
    regw_d  = regw_q;
    data_d  = data_q;
    case (state_q)
      ST_REQ:  if (dmem_req_ready) state_d = ST_RESP;
      ST_RESP: if (dmem_resp_valid) begin
        if (re_q) data_d = ld_data;
        state_d = ST_HOLD;
      end
      ST_HOLD: if (wb_to_mem_ready) state_d = ST_IDLE;
      default: ;
    endcase
    // Accept overrides HOLD->IDLE, giving the bubble-free handoff.
    if (accept) begin
      op_d    = in_op;
      re_d    = in_re;
      we_d    = in_we;
      st_d    = in_st;
      alu_d   = in_alu;
      ra_d    = in_ra;
      regw_d  = in_regw & ~mis_in;
      data_d  = in_alu;
      state_d = ((in_re | in_we) & ~mis_in) ? ST_REQ : ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      st_q    <= '0;
      alu_q   <= '0;
      ra_q    <= '0;
      regw_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      re_q    <= re_d;
      we_q    <= we_d;
      st_q    <= st_d;
      alu_q   <= alu_d;
      ra_q    <= ra_d;
      regw_q  <= regw_d;
      data_q  <= data_d;
    end
  end

`ifdef MEMU_MISALIGN_CHECK_EN
  // Set on the accepting edge, so it is high exactly for the first HOLD cycle.
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= accept & mis_in;
  end
  assign mem_misalign_err = err_q;
`else
  assign mem_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_memu.sv
module tb_memu;
  import memu_pkg::*;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int BW  = 2*DW+AW+6;
  localparam int WBW = DW+AW+1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [BW-1:0]  ex_to_mem_bus;
  logic           ex_to_mem_valid;
  logic           mem_to_ex_ready;
  logic [WBW-1:0] mem_to_wb_bus;
  logic           mem_to_wb_valid;
  logic           wb_to_mem_ready;
  logic           dmem_req_valid, dmem_req_ready;
  logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic           dmem_wen;
  logic [3:0]     dmem_wstrb;
  logic           dmem_resp_valid, dmem_resp_ready;
  logic           mem_misalign_err;

  always #5 clk = ~clk;

  memu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_mem_valid(ex_to_mem_valid),
    .mem_to_ex_ready(mem_to_ex_ready),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_wb_valid(mem_to_wb_valid),
    .wb_to_mem_ready(wb_to_mem_ready),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_ready(dmem_resp_ready), .dmem_rdata(dmem_rdata),
    .mem_misalign_err(mem_misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          req_dly;
    int          rsp_dly;
  } dreq_t;

  logic [WBW-1:0] wb_q[$];
  dreq_t          dq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mkbus(input logic [2:0] op, input logic re, input logic we,
                                          input logic [31:0] st, input logic [31:0] alu,
                                          input logic [4:0] ra, input logic rw);
    return {op, re, we, st, alu, ra, rw};
  endfunction

  task automatic push_wb(input logic [31:0] d, input logic [4:0] ra, input logic rw);
    wb_q.push_back({d, ra, rw});
  endtask

  task automatic push_dm(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] s, input logic [31:0] rd, input int qd, input int rdly);
    dreq_t e;
    e.addr = a; e.wen = w; e.wdata = wd; e.wstrb = s; e.rdata = rd;
    e.req_dly = qd; e.rsp_dly = rdly;
    dq.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [BW-1:0] b, output int waited);
    bit done;
    done = 0;
    waited = 0;
    ex_to_mem_bus = b;
    ex_to_mem_valid = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (mem_to_ex_ready) begin
        @(posedge clk); #1;
        done = 1;
      end else waited++;
    end
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus = {$urandom, $urandom, $urandom};   // must be ignored
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout: got no ready want ready within 60 cycles");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((wb_q.size() != 0 || dq.size() != 0 || mem_to_wb_valid) && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: got wb=%0d dm=%0d pending want 0", wb_q.size(), dq.size());
    end
    @(posedge clk); #1;
  endtask

  // Write-back monitor: pop and compare on every handshake.
  initial begin
    logic [WBW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && mem_to_wb_valid && wb_to_mem_ready) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got %0h want nothing", mem_to_wb_bus);
        end else begin
          e = wb_q.pop_front();
          chk("wb_bus", 64'(mem_to_wb_bus), 64'(e));
        end
      end
    end
  end

  // Memory responder: checks each request, then acks with programmed delays.
  initial begin
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && dmem_req_valid) begin
        dreq_t e;
        logic [31:0] a0, wd0;
        logic [3:0]  s0;
        logic        w0;
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL dmem_unexpected: got addr %0h want no request", dmem_addr);
          e.addr = 0; e.wen = 0; e.wdata = 0; e.wstrb = 0; e.rdata = 0;
          e.req_dly = 0; e.rsp_dly = 0;
        end else begin
          e = dq.pop_front();
          chk("dmem_addr", 64'(dmem_addr), 64'(e.addr));
          chk("dmem_wen", 64'(dmem_wen), 64'(e.wen));
          chk("dmem_wstrb", 64'(dmem_wstrb), 64'(e.wstrb));
          if (e.wen) chk("dmem_wdata", 64'(dmem_wdata), 64'(e.wdata));
        end
        a0 = dmem_addr; wd0 = dmem_wdata; s0 = dmem_wstrb; w0 = dmem_wen;
        for (int k = 0; k < e.req_dly; k++) begin
          @(negedge clk);
          chk("req_hold_valid", 64'(dmem_req_valid), 64'(1));
          chk("req_hold_addr", {dmem_wen, dmem_addr}, {w0, a0});
          chk("req_hold_data", {dmem_wstrb, dmem_wdata}, {s0, wd0});
          chk("req_hold_exready", 64'(mem_to_ex_ready), 64'(0));
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        for (int k = 0; k < e.rsp_dly; k++) @(negedge clk);
        dmem_resp_valid = 1'b1;
        dmem_rdata = e.rdata;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        dmem_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int w, wb2, wc, c;
    ex_to_mem_bus = '0; ex_to_mem_valid = 1'b0; wb_to_mem_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_to_ex_ready, mem_to_wb_valid, dmem_req_valid, dmem_resp_ready,
                     dmem_wen, dmem_wstrb, mem_misalign_err}, 64'(0));
    chk("rst_wbbus", 64'(mem_to_wb_bus), 64'(0));
    chk("rst_dmem", {dmem_addr, dmem_wdata}, 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(mem_to_ex_ready), 64'(1));
    @(posedge clk); #1;

    // Non-memory op, write-back stalled for 3 cycles.
    wb_to_mem_ready = 1'b0;
    push_wb(32'h1234, 5'd5, 1'b1);
    issue(mkbus(OP_LW, 0, 0, 32'h0, 32'h1234, 5'd5, 1'b1), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_hold_valid", 64'(mem_to_wb_valid), 64'(1));
      chk("alu_hold_bus", 64'(mem_to_wb_bus), {26'h0, 32'h1234, 5'd5, 1'b1});
      chk("alu_hold_exready", 64'(mem_to_ex_ready), 64'(0));
    end
    @(posedge clk); #1 wb_to_mem_ready = 1'b1;
    drain();

    // LB, response two cycles after request handshake.
    push_dm(32'h100, 0, 0, 4'b0000, 32'h80FF_0000, 0, 2);
    push_wb(32'hFFFF_FF80, 5'd7, 1'b1);
    issue(mkbus(OP_LB, 1, 0, 32'h5555_5555, 32'h103, 5'd7, 1'b1), w);
    drain();

    push_dm(32'h100, 0, 0, 4'b0000, 32'hBEEF_1234, 0, 0);
    push_wb(32'h0000_BEEF, 5'd8, 1'b1);
    issue(mkbus(OP_LHU, 1, 0, 32'h0, 32'h102, 5'd8, 1'b1), w);
    drain();

    // LW with immediate ack/response: minimum latency.
    push_dm(32'h100, 0, 0, 4'b0000, 32'hBEEF_1234, 0, 0);
    push_wb(32'hBEEF_1234, 5'd9, 1'b1);
    issue(mkbus(OP_LW, 1, 0, 32'h0, 32'h100, 5'd9, 1'b1), w);
    c = 0;
    while (!mem_to_wb_valid && c < 20) begin @(negedge clk); c++; end
    chk("lw_latency", 64'(c), 64'(3));
    drain();

    push_dm(32'h100, 0, 0, 4'b0000, 32'h0000_8001, 1, 0);
    push_wb(32'hFFFF_8001, 5'd10, 1'b1);
    issue(mkbus(OP_LH, 1, 0, 32'h0, 32'h100, 5'd10, 1'b1), w);
    drain();

    push_dm(32'h100, 0, 0, 4'b0000, 32'h0000_9A00, 0, 1);
    push_wb(32'h0000_009A, 5'd11, 1'b1);
    issue(mkbus(OP_LBU, 1, 0, 32'h0, 32'h101, 5'd11, 1'b1), w);
    drain();

    // Stores: write-back carries alu_res.
    push_dm(32'h100, 1, 32'hABAB_ABAB, 4'b0010, 32'h0, 0, 0);
    push_wb(32'h101, 5'd0, 1'b0);
    issue(mkbus(OP_SB, 0, 1, 32'h0000_00AB, 32'h101, 5'd0, 1'b0), w);
    drain();

    push_dm(32'h100, 1, 32'hCAFE_CAFE, 4'b1100, 32'h0, 0, 0);
    push_wb(32'h102, 5'd0, 1'b0);
    issue(mkbus(OP_SH, 0, 1, 32'h0000_CAFE, 32'h102, 5'd0, 1'b0), w);
    drain();

    push_dm(32'h200, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0, 0);
    push_wb(32'h200, 5'd0, 1'b0);
    issue(mkbus(OP_SW, 0, 1, 32'hDEAD_BEEF, 32'h200, 5'd0, 1'b0), w);
    drain();

    // re and we both set: behaves as a load.
    push_dm(32'h104, 0, 0, 4'b0000, 32'h1122_3344, 0, 0);
    push_wb(32'h1122_3344, 5'd12, 1'b1);
    issue(mkbus(OP_LW, 1, 1, 32'hFFFF_FFFF, 32'h104, 5'd12, 1'b1), w);
    drain();

    // Back-to-back: two ALU ops then a store with a 4-cycle request stall.
    push_wb(32'hA0A0_0001, 5'd1, 1'b1);
    push_wb(32'hB0B0_0002, 5'd2, 1'b1);
    push_dm(32'h300, 1, 32'h0102_0304, 4'b1111, 32'h0, 4, 0);
    push_wb(32'h300, 5'd0, 1'b0);
    issue(mkbus(OP_LW, 0, 0, 32'h0, 32'hA0A0_0001, 5'd1, 1'b1), w);
    issue(mkbus(OP_LW, 0, 0, 32'h0, 32'hB0B0_0002, 5'd2, 1'b1), wb2);
    issue(mkbus(OP_SW, 0, 1, 32'h0102_0304, 32'h300, 5'd0, 1'b0), wc);
    chk("b2b_no_bubble_b", 64'(wb2), 64'(0));
    chk("b2b_no_bubble_c", 64'(wc), 64'(0));
    @(negedge clk);
    chk("b2b_req_valid", 64'(dmem_req_valid), 64'(1));
    drain();

`ifdef MEMU_MISALIGN_CHECK_EN
    // Misaligned LW: no request, regW cleared, single error pulse.
    push_wb(32'h102, 5'd9, 1'b0);
    issue(mkbus(OP_LW, 1, 0, 32'h0, 32'h102, 5'd9, 1'b1), w);
    @(negedge clk);
    chk("mis_err_pulse", 64'(mem_misalign_err), 64'(1));
    chk("mis_no_req", 64'(dmem_req_valid), 64'(0));
    @(negedge clk);
    chk("mis_err_clear", 64'(mem_misalign_err), 64'(0));
    drain();
    push_wb(32'h101, 5'd0, 1'b0);
    issue(mkbus(OP_SH, 0, 1, 32'h1234, 32'h101, 5'd0, 1'b0), w);
    @(negedge clk);
    chk("mis_sh_err", 64'(mem_misalign_err), 64'(1));
    drain();
`else
    // Without the check, misaligned accesses proceed with shifted lanes.
    push_dm(32'h100, 0, 0, 4'b0000, 32'hCAFE_F00D, 0, 0);
    push_wb(32'hCAFE_F00D, 5'd9, 1'b1);
    issue(mkbus(OP_LW, 1, 0, 32'h0, 32'h102, 5'd9, 1'b1), w);
    @(negedge clk);
    chk("nomis_err", 64'(mem_misalign_err), 64'(0));
    drain();
    push_dm(32'h100, 1, 32'h1234_1234, 4'b1000, 32'h0, 0, 0);
    push_wb(32'h103, 5'd0, 1'b0);
    issue(mkbus(OP_SH, 0, 1, 32'h1234, 32'h103, 5'd0, 1'b0), w);
    drain();
`endif

    // Reset while waiting in RESP.
    push_dm(32'h100, 0, 0, 4'b0000, 32'hDEAD_0000, 0, 6);
    issue(mkbus(OP_LW, 1, 0, 32'h0, 32'h100, 5'd3, 1'b1), w);
    c = 0;
    while (!dmem_resp_ready && c < 20) begin @(negedge clk); c++; end
    chk("reached_resp", 64'(dmem_resp_ready), 64'(1));
    rst = 1'b0;
    #1;
    chk("rst_resp_ctrl", {mem_to_ex_ready, mem_to_wb_valid, dmem_req_valid, dmem_resp_ready,
                          dmem_wen, dmem_wstrb, mem_misalign_err}, 64'(0));
    chk("rst_resp_bus", 64'(mem_to_wb_bus), 64'(0));
    chk("rst_resp_addr", 64'(dmem_addr), 64'(0));
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
    push_wb(32'h5A5A, 5'd4, 1'b1);
    issue(mkbus(OP_LW, 0, 0, 32'h0, 32'h5A5A, 5'd4, 1'b1), w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
